// File: rtl/midi_tx.sv
// MIDI transmitter: takes one channel or real-time message per handshake, turns it
// into MIDI bytes (with optional running status) and shifts each byte out as UART 8N1.
module midi_tx #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BAUD_RATE      = 31250,
    parameter bit          RUNNING_STATUS = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       midi_valid,
    output logic       midi_ready,
    input  logic [2:0] midi_cmd,
    input  logic [3:0] midi_ch_sysn,
    input  logic [6:0] midi_data0,
    input  logic [6:0] midi_data1,
    output logic       tx,
    output logic       tx_busy
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = 4;
    localparam logic [BIT_W-1:0] STOP_IDX = BIT_W'(9);
    localparam logic [2:0]       CMD_SYS  = 3'd7;

    typedef struct packed {
        logic [2:0] cmd;
        logic [3:0] ch_sysn;
        logic [6:0] data0;
        logic [6:0] data1;
    } midi_msg_t;

    typedef enum logic [1:0] {IDLE, STATUS, DATA0, DATA1} state_t;

    state_t           state_q, state_d;
    midi_msg_t        msg_q, msg_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       last_status_q, last_status_d;
    logic             last_valid_q, last_valid_d;
    logic             tx_d, ready_d, busy_d;

    logic       accept;
    logic       skip_status;
    logic       bit_end;
    logic       byte_end;
    logic [7:0] status_in;
    logic [7:0] status_msg;
    logic [7:0] cur_byte;

    // Registers: message FSM, baud/bit counters, running-status memory, line outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            msg_q         <= '0;
            baud_q        <= '0;
            bit_q         <= '0;
            last_status_q <= '0;
            last_valid_q  <= 1'b0;
            tx            <= 1'b1;
            midi_ready    <= 1'b1;
            tx_busy       <= 1'b0;
        end else begin
            state_q       <= state_d;
            msg_q         <= msg_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            last_status_q <= last_status_d;
            last_valid_q  <= last_valid_d;
            tx            <= tx_d;
            midi_ready    <= ready_d;
            tx_busy       <= busy_d;
        end
    end

    // Next-state and output decode; line outputs lag the FSM by one register stage
    always_comb begin
        state_d       = state_q;
        msg_d         = msg_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        last_status_d = last_status_q;
        last_valid_d  = last_valid_q;
        tx_d          = 1'b1;

        accept      = midi_valid & midi_ready;
        status_in   = {1'b1, midi_cmd, midi_ch_sysn};
        status_msg  = {1'b1, msg_q.cmd, msg_q.ch_sysn};
        skip_status = RUNNING_STATUS && (midi_cmd != CMD_SYS) && last_valid_q
                      && (last_status_q == status_in);
        bit_end     = (baud_q == CNT_W'(DIV - 1));
        byte_end    = bit_end && (bit_q == STOP_IDX);

        case (state_q)
            STATUS:  cur_byte = status_msg;
            DATA0:   cur_byte = {1'b0, msg_q.data0};
            DATA1:   cur_byte = {1'b0, msg_q.data1};
            default: cur_byte = 8'hFF;
        endcase

        ready_d = (state_q == IDLE) && !accept;
        busy_d  = !ready_d;

        if (state_q != IDLE) begin
            if (bit_q == '0)
                tx_d = 1'b0;
            else if (bit_q == STOP_IDX)
                tx_d = 1'b1;
            else
                tx_d = cur_byte[3'(bit_q - BIT_W'(1))];
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    msg_d   = {midi_cmd, midi_ch_sysn, midi_data0, midi_data1};
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = skip_status ? DATA0 : STATUS;
                end
            end
            default: begin
                if (bit_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + BIT_W'(1);
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
                // Byte boundary: pick the next byte of the message or finish
                if (byte_end) begin
                    bit_d = '0;
                    case (state_q)
                        STATUS: begin
                            if (msg_q.cmd != CMD_SYS) begin
                                last_status_d = status_msg;
                                last_valid_d  = RUNNING_STATUS;
                            end else if (!msg_q.ch_sysn[3]) begin
                                last_valid_d  = 1'b0;
                            end
                            state_d = (msg_q.cmd == CMD_SYS) ? IDLE : DATA0;
                        end
                        DATA0: begin
                            state_d = (msg_q.cmd == 3'd4 || msg_q.cmd == 3'd5) ? IDLE : DATA1;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: directed and random messages, serial line decoded by a
// bench-side UART sampler and compared with a byte-level MIDI reference model.
module tb_midi_tx;

    localparam int unsigned CLK_FREQ  = 1_600_000;
    localparam int unsigned BAUD_RATE = 100_000;
    localparam int unsigned DIV       = CLK_FREQ / BAUD_RATE;
    localparam int          LIMIT     = 40 * DIV;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       valid0  = 1'b0;
    logic       valid1  = 1'b0;
    logic [2:0] cmd     = '0;
    logic [3:0] ch      = '0;
    logic [6:0] d0      = '0;
    logic [6:0] d1      = '0;
    logic       ready0, ready1, tx0, tx1, busy0, busy1;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         last_st [2] = '{-1, -1};
    bit         rs [2]      = '{1'b1, 1'b0};
    logic [8:0] act0[$];
    logic [8:0] act1[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    midi_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .RUNNING_STATUS(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .midi_valid(valid0), .midi_ready(ready0),
        .midi_cmd(cmd), .midi_ch_sysn(ch), .midi_data0(d0), .midi_data1(d1),
        .tx(tx0), .tx_busy(busy0)
    );

    midi_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .RUNNING_STATUS(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .midi_valid(valid1), .midi_ready(ready1),
        .midi_cmd(cmd), .midi_ch_sysn(ch), .midi_data0(d0), .midi_data1(d1),
        .tx(tx1), .tx_busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic get_tx(input int k);
        return (k == 0) ? tx0 : tx1;
    endfunction

    function automatic logic get_ready(input int k);
        return (k == 0) ? ready0 : ready1;
    endfunction

    function automatic logic get_busy(input int k);
        return (k == 0) ? busy0 : busy1;
    endfunction

    task automatic set_valid(input int k, input logic v);
        if (k == 0) valid0 = v;
        else        valid1 = v;
    endtask

    // MIDI byte rules: status unless running status repeats, then data per command
    task automatic model(input int k, input int c, input int chn, input int a, input int b);
        int st;
        st = 128 + c * 16 + chn;
        exp_q.delete();
        if (!(c != 7 && rs[k] && last_st[k] == st)) exp_q.push_back(9'(256 + st));
        if (c != 7) exp_q.push_back(9'(256 + a));
        if (c <= 3 || c == 6) exp_q.push_back(9'(256 + b));
        if (c != 7)      last_st[k] = st;
        else if (chn < 8) last_st[k] = -1;
    endtask

    // UART 8N1 line sampler: mid-bit samples, pushes {stop, data}
    task automatic monitor(input int k);
        logic       prev;
        logic       cur;
        logic [8:0] b;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            cur = get_tx(k);
            if (prev === 1'b1 && cur === 1'b0) begin
                repeat (DIV / 2 - 1) @(posedge clk);
                for (int i = 0; i < 9; i++) begin
                    repeat (DIV) @(posedge clk);
                    b[i] = get_tx(k);
                end
                if (k == 0) act0.push_back(b);
                else        act1.push_back(b);
                cur = b[8];
            end
            prev = cur;
        end
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (get_ready(k) !== 1'b1 && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ready_before_send", 32'(get_ready(k)), 1);
    endtask

    // One message: handshake, latency, length in cycles and decoded bytes
    task automatic send_msg(input int k, input int c, input int chn, input int a, input int b,
                            input bit pulse);
        int         n;
        logic [8:0] got;
        model(k, c, chn, a, b);
        wait_ready(k);
        cmd = 3'(c); ch = 4'(chn); d0 = 7'(a); d1 = 7'(b);
        set_valid(k, 1'b1);
        @(posedge clk); #1;
        set_valid(k, 1'b0);
        cmd = 3'($urandom); ch = 4'($urandom); d0 = 7'($urandom); d1 = 7'($urandom);
        check_eq("accept_ready", 32'(get_ready(k)), 0);
        check_eq("accept_busy", 32'(get_busy(k)), 1);
        check_eq("tx_before_start", 32'(get_tx(k)), 1);
        @(posedge clk); #1;
        check_eq("start_bit", 32'(get_tx(k)), 0);
        n = 1;
        while (get_ready(k) !== 1'b1 && n < LIMIT) begin
            set_valid(k, pulse && (n >= 3 * DIV + 3) && (n < 3 * DIV + 8));
            if (pulse && n == 3 * DIV + 5)
                check_eq("pulse_ready_low", 32'(get_ready(k)), 0);
            @(posedge clk); #1;
            n++;
        end
        set_valid(k, 1'b0);
        check_eq("msg_cycles", 32'(n), 32'(10 * DIV * exp_q.size() + 1));
        check_eq("end_busy", 32'(get_busy(k)), 0);
        check_eq("end_tx_idle", 32'(get_tx(k)), 1);
        check_eq("byte_count", 32'((k == 0) ? act0.size() : act1.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < ((k == 0) ? act0.size() : act1.size())) begin
                got = (k == 0) ? act0[i] : act1[i];
                check_eq("byte", 32'(got), 32'(exp_q[i]));
            end
        end
        act0.delete();
        act1.delete();
    endtask

    // Reset during bit 4 of the first byte sent, then settle and clear model state
    task automatic abort_msg(input int c, input int chn, input int a, input int b);
        wait_ready(0);
        cmd = 3'(c); ch = 4'(chn); d0 = 7'(a); d1 = 7'(b);
        valid0 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0;
        repeat (1 + 5 * DIV + DIV / 2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("abort_tx", 32'(tx0), 1);
        check_eq("abort_ready", 32'(ready0), 1);
        check_eq("abort_busy", 32'(busy0), 0);
        repeat (12 * DIV) @(posedge clk);
        #1;
        reset_n = 1'b1;
        act0.delete();
        act1.delete();
        last_st[0] = -1;
        last_st[1] = -1;
        @(posedge clk); #1;
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        int c, chn, pc, pch;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dut0", {29'd0, tx0, ready0, busy0}, 32'b110);
        check_eq("rst_dut1", {29'd0, tx1, ready1, busy1}, 32'b110);
        reset_n = 1'b1;
        @(posedge clk); #1;

        send_msg(0, 1, 2, 'h3C, 'h64, 1'b0);
        send_msg(0, 1, 2, 'h40, 'h00, 1'b0);
        send_msg(1, 1, 2, 'h3C, 'h64, 1'b0);
        send_msg(1, 1, 2, 'h40, 'h00, 1'b0);

        send_msg(0, 4, 0, 'h05, 'h11, 1'b0);
        send_msg(0, 7, 8, 'h22, 'h33, 1'b0);
        send_msg(0, 4, 0, 'h06, 'h44, 1'b0);
        send_msg(0, 7, 2, 'h01, 'h02, 1'b0);
        send_msg(0, 4, 0, 'h07, 'h00, 1'b0);

        send_msg(0, 1, 5, 'h12, 'h34, 1'b1);
        send_msg(0, 1, 5, 'h56, 'h78, 1'b1);

        send_msg(0, 1, 2, 'h3C, 'h64, 1'b0);
        abort_msg(1, 2, 'h3C, 'h64);
        send_msg(0, 1, 2, 'h3C, 'h64, 1'b0);
        send_msg(0, 7, 2, 'h00, 'h00, 1'b0);
        abort_msg(1, 2, 'h3C, 'h64);
        send_msg(0, 1, 2, 'h3C, 'h64, 1'b0);

        pc = 0;
        pch = 0;
        for (int i = 0; i < 64; i++) begin
            if (pc != 7 && $urandom_range(0, 2) == 0) begin
                c   = pc;
                chn = pch;
            end else begin
                c   = $urandom_range(0, 7);
                chn = $urandom_range(0, 15);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            send_msg(0, c, chn, $urandom_range(0, 127), $urandom_range(0, 127), 1'b0);
            pc  = c;
            pch = chn;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
